// File: rtl/pipeline_mem_wb_skid_if.sv
// MEM->WB stage bus: MEM-side beat fields plus the held/formatted WB-side view.
// slave is the stage's view; master is the view of whoever drives MEM and sinks WB.
interface pipeline_mem_wb_skid_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RF_ADDR_W = 5
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [ADDR_W-1:0]    addr_i;
    logic [RF_ADDR_W-1:0] rf_dst_addr_i;
    logic                 rf_we_i;
    logic                 dm_re_i;
    logic [1:0]           ld_size_i;
    logic                 ld_sign_i;
    logic [DATA_W-1:0]    mem_data_i;
    logic [DATA_W-1:0]    alu_rslt_i;

    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [ADDR_W-1:0]    addr_o;
    logic [RF_ADDR_W-1:0] rf_dst_addr_o;
    logic                 rf_we_o;
    logic                 dm_re_o;
    logic [DATA_W-1:0]    mem_data_o;
    logic [DATA_W-1:0]    alu_rslt_o;
    logic [DATA_W-1:0]    wb_data_o;

    modport slave (
        input  in_valid_i, addr_i, rf_dst_addr_i, rf_we_i, dm_re_i,
               ld_size_i, ld_sign_i, mem_data_i, alu_rslt_i, out_ready_i,
        output in_ready_o, out_valid_o, addr_o, rf_dst_addr_o, rf_we_o,
               dm_re_o, mem_data_o, alu_rslt_o, wb_data_o
    );

    modport master (
        output in_valid_i, addr_i, rf_dst_addr_i, rf_we_i, dm_re_i,
               ld_size_i, ld_sign_i, mem_data_i, alu_rslt_i, out_ready_i,
        input  in_ready_o, out_valid_o, addr_o, rf_dst_addr_o, rf_we_o,
               dm_re_o, mem_data_o, alu_rslt_o, wb_data_o
    );
endinterface

// File: rtl/pipeline_mem_wb_skid.sv
// MEM->WB pipeline register with a main+skid entry pair, flush, and load-data
// formatting (lane select, sign/zero extend) feeding the register-file write port.
module pipeline_mem_wb_skid #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RF_ADDR_W = 5,
    parameter bit PIPE_EN   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    pipeline_mem_wb_skid_if.slave       bus
);
    localparam int LANE_W = $clog2(DATA_W / 8);

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [RF_ADDR_W-1:0] rf_dst;
        logic                 rf_we;
        logic                 dm_re;
        logic [1:0]           ld_size;
        logic                 ld_sign;
        logic [DATA_W-1:0]    mem_data;
        logic [DATA_W-1:0]    alu;
    } entry_t;

    // Everything is widened to 64 bits so one path serves both DATA_W values
    // without zero-width replications; the result is truncated back.
    function automatic logic [DATA_W-1:0] fmt_load(
        input logic [LANE_W-1:0] lane,
        input logic [1:0]        size,
        input logic              sign,
        input logic [DATA_W-1:0] data
    );
        logic [63:0] wide;
        logic [63:0] sh;
        logic [63:0] ext;
        int          sa;
        wide = 64'(data);
        sa   = 0;
        case (size)
            2'b00:   sa = 8  * int'(lane);
            2'b01:   sa = 16 * (int'(lane) >> 1);
            default: sa = 32 * (int'(lane) >> 2);
        endcase
        sh = wide >> sa;
        case (size)
            2'b00:   ext = {{56{sign & sh[7]}},  sh[7:0]};
            2'b01:   ext = {{48{sign & sh[15]}}, sh[15:0]};
            2'b10:   ext = {{32{sign & sh[31]}}, sh[31:0]};
            default: ext = (DATA_W == 64) ? wide : {{32{sign & sh[31]}}, sh[31:0]};
        endcase
        return ext[DATA_W-1:0];
    endfunction

    entry_t in_ent;
    entry_t out_ent;
    logic   out_vld;
    logic   in_rdy;

    always_comb begin
        in_ent          = '0;
        in_ent.addr     = bus.addr_i;
        in_ent.rf_dst   = bus.rf_dst_addr_i;
        in_ent.rf_we    = bus.rf_we_i;
        in_ent.dm_re    = bus.dm_re_i;
        in_ent.ld_size  = bus.ld_size_i;
        in_ent.ld_sign  = bus.ld_sign_i;
        in_ent.mem_data = bus.mem_data_i;
        in_ent.alu      = bus.alu_rslt_i;
    end

    if (PIPE_EN) begin : g_pipe
        entry_t main_q, main_d;
        entry_t skid_q, skid_d;
        logic   main_valid_q, main_valid_d;
        logic   skid_valid_q, skid_valid_d;
        logic   accept;

        // in_ready depends only on skid occupancy, so out_ready_i never
        // reaches in_ready_o combinationally.
        assign accept = bus.in_valid_i & ~skid_valid_q;

        always_comb begin
            main_d       = main_q;
            skid_d       = skid_q;
            main_valid_d = main_valid_q;
            skid_valid_d = skid_valid_q;
            if (flush_i) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end else if (!main_valid_q || bus.out_ready_i) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    main_d       = in_ent;
                    main_valid_d = 1'b1;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d       = in_ent;
                skid_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_q       <= '0;
                skid_q       <= '0;
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
            end else begin
                main_q       <= main_d;
                skid_q       <= skid_d;
                main_valid_q <= main_valid_d;
                skid_valid_q <= skid_valid_d;
            end
        end

        assign out_ent = main_q;
        assign out_vld = main_valid_q;
        assign in_rdy  = ~skid_valid_q;
    end else begin : g_pass
        logic unused_pass;
        assign unused_pass = &{1'b0, clk, rst};
        assign out_ent     = in_ent;
        assign out_vld     = bus.in_valid_i & ~flush_i;
        assign in_rdy      = bus.out_ready_i;
    end

    assign bus.in_ready_o    = in_rdy;
    assign bus.out_valid_o   = out_vld;
    assign bus.addr_o        = out_ent.addr;
    assign bus.rf_dst_addr_o = out_ent.rf_dst;
    assign bus.rf_we_o       = out_ent.rf_we & out_vld;
    assign bus.dm_re_o       = out_ent.dm_re;
    assign bus.mem_data_o    = out_ent.mem_data;
    assign bus.alu_rslt_o    = out_ent.alu;
    assign bus.wb_data_o     = out_ent.dm_re
                             ? fmt_load(out_ent.addr[LANE_W-1:0], out_ent.ld_size,
                                        out_ent.ld_sign, out_ent.mem_data)
                             : out_ent.alu;
endmodule

// File: tb/tb_pipeline_mem_wb_skid.sv
// Bench for pipeline_mem_wb_skid: registered (PIPE_EN=1) and passthrough (PIPE_EN=0)
// instances share one stimulus stream; a 2-deep queue model predicts the registered one.
module tb_pipeline_mem_wb_skid;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] addr, mem, alu;
    logic [4:0]  rfd;
    logic        rfwe, dmre, ldsign;
    logic [1:0]  ldsz;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    pipeline_mem_wb_skid_if #(.DATA_W(32), .ADDR_W(32), .RF_ADDR_W(5)) bus1 ();
    pipeline_mem_wb_skid_if #(.DATA_W(32), .ADDR_W(32), .RF_ADDR_W(5)) bus0 ();

    assign bus1.in_valid_i = in_valid;  assign bus0.in_valid_i = in_valid;
    assign bus1.out_ready_i = out_ready; assign bus0.out_ready_i = out_ready;
    assign bus1.addr_i = addr;          assign bus0.addr_i = addr;
    assign bus1.rf_dst_addr_i = rfd;    assign bus0.rf_dst_addr_i = rfd;
    assign bus1.rf_we_i = rfwe;         assign bus0.rf_we_i = rfwe;
    assign bus1.dm_re_i = dmre;         assign bus0.dm_re_i = dmre;
    assign bus1.ld_size_i = ldsz;       assign bus0.ld_size_i = ldsz;
    assign bus1.ld_sign_i = ldsign;     assign bus0.ld_sign_i = ldsign;
    assign bus1.mem_data_i = mem;       assign bus0.mem_data_i = mem;
    assign bus1.alu_rslt_i = alu;       assign bus0.alu_rslt_i = alu;

    pipeline_mem_wb_skid #(.DATA_W(32), .ADDR_W(32), .RF_ADDR_W(5), .PIPE_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(bus1));
    pipeline_mem_wb_skid #(.DATA_W(32), .ADDR_W(32), .RF_ADDR_W(5), .PIPE_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(bus0));

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  rfd;
        logic        rfwe, dmre;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] mem, alu;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference load formatting: pick bytes out of a byte array, then extend.
    function automatic logic [31:0] mfmt(input logic [31:0] a, input logic [1:0] sz,
                                         input logic sg, input logic [31:0] d);
        logic [7:0]  b [4];
        logic [15:0] h;
        int          l;
        for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        l = int'(a[1:0]);
        if (sz == 2'b00) return sg ? {{24{b[l][7]}}, b[l]} : {24'h0, b[l]};
        if (sz == 2'b01) begin
            h = {b[(l & 2) + 1], b[l & 2]};
            return sg ? {{16{h[15]}}, h} : {16'h0, h};
        end
        return d;
    endfunction

    function automatic ent_t cur_ent();
        ent_t e;
        e.addr = addr; e.rfd = rfd; e.rfwe = rfwe; e.dmre = dmre;
        e.sz = ldsz; e.sg = ldsign; e.mem = mem; e.alu = alu;
        return e;
    endfunction

    // Stage as a 2-deep FIFO: ready while fewer than two beats are held.
    always @(posedge clk or posedge rst) begin : model
        int n;
        if (rst || flush) q.delete();
        else begin
            n = q.size();
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) q.push_back(cur_ent());
        end
    end

    always @(negedge clk) begin : compare
        ent_t h;
        logic v;
        v = (q.size() > 0);
        chk("p1_in_ready", bus1.in_ready_o, q.size() < 2);
        chk("p1_out_valid", bus1.out_valid_o, v);
        if (rst) begin
            chk("p1_rst_wb", bus1.wb_data_o, 0);
            chk("p1_rst_alu", bus1.alu_rslt_o, 0);
            chk("p1_rst_addr", bus1.addr_o, 0);
            chk("p1_rst_mem", bus1.mem_data_o, 0);
        end
        if (v) begin
            h = q[0];
            chk("p1_addr", bus1.addr_o, h.addr);
            chk("p1_rfd", bus1.rf_dst_addr_o, h.rfd);
            chk("p1_rf_we", bus1.rf_we_o, h.rfwe);
            chk("p1_dm_re", bus1.dm_re_o, h.dmre);
            chk("p1_mem", bus1.mem_data_o, h.mem);
            chk("p1_alu", bus1.alu_rslt_o, h.alu);
            chk("p1_wb", bus1.wb_data_o, h.dmre ? mfmt(h.addr, h.sz, h.sg, h.mem) : h.alu);
        end else begin
            chk("p1_rf_we_idle", bus1.rf_we_o, 0);
        end
        chk("p0_out_valid", bus0.out_valid_o, in_valid & ~flush);
        chk("p0_in_ready", bus0.in_ready_o, out_ready);
        chk("p0_rf_we", bus0.rf_we_o, rfwe & in_valid & ~flush);
        chk("p0_addr", bus0.addr_o, addr);
        chk("p0_rfd", bus0.rf_dst_addr_o, rfd);
        chk("p0_dm_re", bus0.dm_re_o, dmre);
        chk("p0_mem", bus0.mem_data_o, mem);
        chk("p0_alu", bus0.alu_rslt_o, alu);
        chk("p0_wb", bus0.wb_data_o, dmre ? mfmt(addr, ldsz, ldsign, mem) : alu);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        in_valid = v; alu = a; rfwe = 1'b1; dmre = 1'b0;
        addr = $urandom; mem = $urandom; rfd = 5'($urandom);
        ldsz = 2'($urandom); ldsign = 1'($urandom);
    endtask

    logic [1:0]  lf_lo [5] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b10};
    logic [1:0]  lf_sz [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    logic        lf_sg [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] lf_ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000007F, 32'h80FF7F01};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        addr = '0; mem = '0; alu = '0; rfd = '0; rfwe = 1'b0; dmre = 1'b0;
        ldsz = '0; ldsign = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", bus1.in_ready_o, 1);
        chk("rst_out_valid", bus1.out_valid_o, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++)
            chk("model_fmt", mfmt({30'h0, lf_lo[i]}, lf_sz[i], lf_sg[i], 32'h80FF7F01), lf_ex[i]);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h11 * (i + 1));
            step();
            chk("stream_alu", bus1.alu_rslt_o, 32'h11 * (i + 1));
            chk("stream_valid", bus1.out_valid_o, 1);
            chk("stream_ready", bus1.in_ready_o, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", bus1.out_valid_o, 0);

        // Back-pressure fills main and skid.
        out_ready = 1'b0;
        drive(1'b1, 32'hA); step();
        drive(1'b1, 32'hB); step();
        in_valid = 1'b0;
        chk("bp_ready_low", bus1.in_ready_o, 0);
        chk("bp_hold_a", bus1.alu_rslt_o, 32'hA);
        step();
        chk("bp_still_a", bus1.alu_rslt_o, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_then_b", bus1.alu_rslt_o, 32'hB);
        chk("bp_ready_back", bus1.in_ready_o, 1);
        drive(1'b1, 32'hC); step();
        chk("bp_then_c", bus1.alu_rslt_o, 32'hC);
        in_valid = 1'b0;
        step();

        // Flush with both entries full and a beat arriving.
        out_ready = 1'b0;
        drive(1'b1, 32'hD); step();
        drive(1'b1, 32'hE); step();
        drive(1'b1, 32'hF); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", bus1.out_valid_o, 0);
        chk("fl_rf_we", bus1.rf_we_o, 0);
        chk("fl_ready", bus1.in_ready_o, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_ghost", bus1.out_valid_o, 0);
        end

        // Asynchronous reset with two beats held.
        out_ready = 1'b0;
        drive(1'b1, 32'h6); step();
        drive(1'b1, 32'h7); step();
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("ar_valid", bus1.out_valid_o, 0);
        chk("ar_rf_we", bus1.rf_we_o, 0);
        chk("ar_ready", bus1.in_ready_o, 1);
        chk("ar_wb", bus1.wb_data_o, 0);
        step();
        rst = 1'b0;
        drive(1'b1, 32'h1234); step();
        chk("ar_first_valid", bus1.out_valid_o, 1);
        chk("ar_first_alu", bus1.alu_rslt_o, 32'h1234);
        in_valid = 1'b0;
        step();

        // Load formatting, combinational and one cycle later through the register.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; dmre = 1'b1; mem = 32'h80FF7F01; alu = $urandom;
            addr = {30'($urandom), lf_lo[i]}; ldsz = lf_sz[i]; ldsign = lf_sg[i];
            #1;
            chk("lf_p0", bus0.wb_data_o, lf_ex[i]);
            step();
            chk("lf_p1", bus1.wb_data_o, lf_ex[i]);
        end
        dmre = 1'b0; alu = 32'hCAFE0001;
        #1;
        chk("lf_alu_sel", bus0.wb_data_o, 32'hCAFE0001);
        rfwe = 1'b1; flush = 1'b1;
        #1;
        chk("p0_flush_valid", bus0.out_valid_o, 0);
        chk("p0_flush_we", bus0.rf_we_o, 0);
        flush = 1'b0;
        #1;
        chk("p0_valid", bus0.out_valid_o, 1);
        chk("p0_we", bus0.rf_we_o, 1);
        step();

        // Random traffic with occasional flush and asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            addr = $urandom; mem = $urandom; alu = $urandom; rfd = 5'($urandom);
            rfwe = 1'($urandom); dmre = 1'($urandom); ldsz = 2'($urandom);
            ldsign = 1'($urandom);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
